// File: rtl/ecc_pkg.sv
// Shared types for the ECC read-error monitor: width constants, scrub state
// encoding and the per-beat error classification.
package ecc_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ECC_WIDTH  = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } scrub_state_e;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        UE    = 2'd2
    } err_class_e;

    // A double error dominates; a simultaneous single flag does not downgrade it.
    function automatic err_class_e classify(input logic valid,
                                            input logic single_err,
                                            input logic double_err);
        err_class_e cls;
        cls = CLEAN;
        if (valid && double_err) begin
            cls = UE;
        end else if (valid && single_err) begin
            cls = CE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with synchronous clear; a clear and an increment in
// the same cycle leave the count at one.
module ecc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = clr_i ? '0 : count_q;
        if (inc_i && (count_d != {WIDTH{1'b1}})) begin
            count_d = count_d + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ecc_rd_err_monitor.sv
// Registered error-handling stage behind the SECDED decoder: forwards beats,
// counts CE/UE, logs the most severe error and (with ECC_SCRUB_WRITEBACK_EN) queues a scrub.
module ecc_rd_err_monitor #(
    parameter int DATA_WIDTH = ecc_pkg::DATA_WIDTH,
    parameter int ECC_WIDTH  = ecc_pkg::ECC_WIDTH,
    parameter int ADDR_WIDTH = 28,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_single_err,
    input  logic                  rd_double_err,
    input  logic [ECC_WIDTH-1:0]  rd_syndrome,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ue,
    output logic                  scrub_valid,
    input  logic                  scrub_ready,
    output logic [ADDR_WIDTH-1:0] scrub_addr,
    output logic [DATA_WIDTH-1:0] scrub_data,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  ce_count,
    output logic [CNT_WIDTH-1:0]  ue_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  log_valid,
    output logic                  log_ue,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic [ECC_WIDTH-1:0]  log_syndrome,
    output logic                  irq
);

    import ecc_pkg::*;

    err_class_e cls;
    logic       is_ce;
    logic       is_ue;
    logic       drop_inc;

    assign cls   = classify(rd_valid, rd_single_err, rd_double_err);
    assign is_ce = (cls == CE);
    assign is_ue = (cls == UE);

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_ue_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ue_q    <= 1'b0;
        end else begin
            out_valid_q <= rd_valid;
            out_data_q  <= rd_data;
            out_ue_q    <= is_ue;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ue    = out_ue_q;

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_ce_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .inc_i(is_ce), .count_o(ce_count)
    );
    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_ue_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .inc_i(is_ue), .count_o(ue_count)
    );
    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .inc_i(drop_inc), .count_o(drop_count)
    );

    logic                  log_valid_q, log_valid_d;
    logic                  log_ue_q, log_ue_d;
    logic [ADDR_WIDTH-1:0] log_addr_q, log_addr_d;
    logic [ECC_WIDTH-1:0]  log_syn_q, log_syn_d;
    logic                  held_valid;
    logic                  held_ue;
    logic                  capture;

    // The capture decision sees the log as it stands after a same-cycle clear.
    always_comb begin
        held_valid  = log_valid_q & ~clr;
        held_ue     = log_ue_q & ~clr;
        capture     = (is_ce | is_ue) & (~held_valid | (is_ue & ~held_ue));
        log_valid_d = held_valid;
        log_ue_d    = held_ue;
        log_addr_d  = clr ? '0 : log_addr_q;
        log_syn_d   = clr ? '0 : log_syn_q;
        if (capture) begin
            log_valid_d = 1'b1;
            log_ue_d    = is_ue;
            log_addr_d  = rd_addr;
            log_syn_d   = rd_syndrome;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_valid_q <= 1'b0;
            log_ue_q    <= 1'b0;
            log_addr_q  <= '0;
            log_syn_q   <= '0;
        end else begin
            log_valid_q <= log_valid_d;
            log_ue_q    <= log_ue_d;
            log_addr_q  <= log_addr_d;
            log_syn_q   <= log_syn_d;
        end
    end

    assign log_valid    = log_valid_q;
    assign log_ue       = log_ue_q;
    assign log_addr     = log_addr_q;
    assign log_syndrome = log_syn_q;
    assign irq          = log_valid_q & log_ue_q;

`ifdef ECC_SCRUB_WRITEBACK_EN
    // scrub_valid/scrub_ready: the request is presented while in S_REQ and is
    // consumed on any cycle where both are high; addr/data hold until then.
    scrub_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q;
    logic [DATA_WIDTH-1:0] slot_data_q;
    logic                  load_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_addr_q <= '0;
            slot_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_slot) begin
                slot_addr_q <= rd_addr;
                slot_data_q <= rd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (is_ce) state_d = S_REQ;
            S_REQ:   if (scrub_ready && !is_ce) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scrub_valid = (state_q == S_REQ);
        load_slot   = is_ce & ((state_q == S_IDLE) | scrub_ready);
        drop_inc    = is_ce & (state_q == S_REQ) & ~scrub_ready;
    end

    assign scrub_addr = slot_addr_q;
    assign scrub_data = slot_data_q;
`else
    logic unused_scrub_ready;

    assign unused_scrub_ready = scrub_ready;
    assign scrub_valid        = 1'b0;
    assign scrub_addr         = '0;
    assign scrub_data         = '0;
    assign drop_inc           = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_rd_err_monitor.sv
// Scoreboard bench for ecc_rd_err_monitor: directed scenarios followed by random
// traffic, checked against a behavioural model of counters, log and scrub slot.
module tb_ecc_rd_err_monitor;

  localparam int DW   = 64;
  localparam int EW   = 8;
  localparam int AW   = 28;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_single_err = 1'b0;
  logic          rd_double_err = 1'b0;
  logic [EW-1:0] rd_syndrome = '0;
  logic          scrub_ready = 1'b0;
  logic          clr = 1'b0;
  logic          out_valid, out_ue, scrub_valid, log_valid, log_ue, irq;
  logic [DW-1:0] out_data, scrub_data;
  logic [AW-1:0] scrub_addr, log_addr;
  logic [EW-1:0] log_syndrome;
  logic [CW-1:0] ce_count, ue_count, drop_count;

  always #5 clk = ~clk;

  ecc_rd_err_monitor #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_single_err(rd_single_err), .rd_double_err(rd_double_err), .rd_syndrome(rd_syndrome),
    .out_valid(out_valid), .out_data(out_data), .out_ue(out_ue),
    .scrub_valid(scrub_valid), .scrub_ready(scrub_ready), .scrub_addr(scrub_addr),
    .scrub_data(scrub_data), .clr(clr), .ce_count(ce_count), .ue_count(ue_count),
    .drop_count(drop_count), .log_valid(log_valid), .log_ue(log_ue), .log_addr(log_addr),
    .log_syndrome(log_syndrome), .irq(irq)
  );

  typedef struct {
    logic          out_valid;
    int            ce;
    int            ue;
    int            drop;
    logic          log_valid;
    logic          log_ue;
    logic [AW-1:0] log_addr;
    logic [EW-1:0] log_syn;
    logic          irq;
    logic          sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
  } state_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          ue;
  } beat_t;

  state_t exp_q[$];
  beat_t  beat_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     stim_done = 0;

  // reference model state
  int            m_ce, m_ue, m_drop;
  bit            m_lv, m_lue, m_pend;
  logic [AW-1:0] m_la, m_sa;
  logic [EW-1:0] m_ls;
  logic [DW-1:0] m_sd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_ce = 0; m_ue = 0; m_drop = 0;
    m_lv = 0; m_lue = 0; m_la = '0; m_ls = '0;
    m_pend = 0; m_sa = '0; m_sd = '0;
  endtask

  // One clock of stimulus: drive, advance the model, push the expectation.
  task automatic step(input bit r, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit se, input bit de, input logic [EW-1:0] syn,
                      input bit rdy, input bit c);
    state_t e;
    beat_t  b;
    bit     ce_ev, ue_ev;
    @(negedge clk);
    #1;
    rst = r; rd_valid = v; rd_addr = a; rd_data = d;
    rd_single_err = se; rd_double_err = de; rd_syndrome = syn;
    scrub_ready = rdy; clr = c;
    ue_ev = v && de;
    ce_ev = v && se && !de;
    if (r) begin
      model_reset();
    end else begin
      if (c) begin
        m_ce = 0; m_ue = 0; m_drop = 0; m_lv = 0; m_lue = 0; m_la = '0; m_ls = '0;
      end
      if (ce_ev && m_ce < CMAX) m_ce++;
      if (ue_ev && m_ue < CMAX) m_ue++;
      if ((ce_ev || ue_ev) && (!m_lv || (ue_ev && !m_lue))) begin
        m_lv = 1; m_lue = ue_ev; m_la = a; m_ls = syn;
      end
`ifdef ECC_SCRUB_WRITEBACK_EN
      if (ce_ev) begin
        if (!m_pend || rdy) begin
          m_pend = 1; m_sa = a; m_sd = d;
        end else if (m_drop < CMAX) begin
          m_drop++;
        end
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
`endif
      if (v) begin
        b.data = d; b.ue = ue_ev;
        beat_q.push_back(b);
      end
    end
    e.out_valid = !r && v;
    e.ce = m_ce; e.ue = m_ue; e.drop = m_drop;
    e.log_valid = m_lv; e.log_ue = m_lue; e.log_addr = m_la; e.log_syn = m_ls;
    e.irq = m_lv && m_lue;
    e.sv = m_pend; e.sa = m_sa; e.sd = m_sd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, 0, 0, '0, rdy, 0);
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit se, input bit de,
                      input logic [EW-1:0] syn, input bit rdy);
    step(0, 1, a, d, se, de, syn, rdy, 0);
  endtask

  // Monitor: state every cycle, forwarded beats whenever out_valid is high.
  initial begin
    state_t e;
    beat_t  b;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, e.out_valid);
        check("ce_count", ce_count, e.ce);
        check("ue_count", ue_count, e.ue);
        check("drop_count", drop_count, e.drop);
        check("log_valid", log_valid, e.log_valid);
        check("log_ue", log_ue, e.log_ue);
        check("log_addr", log_addr, e.log_addr);
        check("log_syndrome", log_syndrome, e.log_syn);
        check("irq", irq, e.irq);
        check("scrub_valid", scrub_valid, e.sv);
        check("scrub_addr", scrub_addr, e.sa);
        check("scrub_data", scrub_data, e.sd);
      end
      if (out_valid === 1'b1 && !rst) begin
        if (beat_q.size() == 0) begin
          fail_now("out_valid without an expected beat");
        end else begin
          b = beat_q.pop_front();
          check("out_data", out_data, b.data);
          check("out_ue", out_ue, b.ue);
        end
      end
    end
  end

  initial begin
    int r;
    bit v, se, de;
    model_reset();
    repeat (3) step(1, 0, '0, '0, 0, 0, '0, 0, 0);

    // clean beats
    for (int i = 0; i < 4; i++) beat(AW'(32'h100 + i), {32'h1234_0000, 32'(i)}, 0, 0, '0, 0);
    idle(0);

    // CE held without ready, then accepted
    beat(AW'(32'h0A5), 64'hDEAD_BEEF_0000_0001, 1, 0, 8'h83, 0);
    repeat (3) idle(0);
    idle(1);
    idle(0);

    // drop while busy, then reload with ready in the same cycle
    beat(AW'(32'h10), 64'h10, 1, 0, 8'h11, 0);
    beat(AW'(32'h20), 64'h20, 1, 0, 8'h22, 0);
    beat(AW'(32'h20), 64'h20, 1, 0, 8'h22, 1);
    idle(0);
    idle(1);

    // UE overrides CE, earliest UE is kept
    step(0, 0, '0, '0, 0, 0, '0, 0, 1);
    beat(AW'(32'h30), 64'h30, 1, 0, 8'h33, 1);
    beat(AW'(32'h40), 64'h40, 0, 1, 8'h44, 1);
    beat(AW'(32'h50), 64'h50, 1, 1, 8'h55, 1);
    idle(1);

    // saturation of ue/ce/drop counters
    for (int i = 0; i < CMAX + 3; i++) beat(AW'(i), 64'(i), 0, 1, 8'hF0, 0);
    for (int i = 0; i < CMAX + 3; i++) beat(AW'(i + 1000), 64'(i), 1, 0, 8'h0F, 0);
    idle(0);

    // clear together with a CE
    step(0, 1, AW'(32'h77), 64'h77, 1, 0, 8'h07, 1, 1);
    idle(0);

    // reset while a scrub is pending
    beat(AW'(32'h99), 64'h99, 1, 0, 8'h09, 0);
    step(1, 0, '0, '0, 0, 0, '0, 0, 0);
    idle(0);
    idle(1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 3) != 0);
      se = (r >= 4 && r <= 6) || r == 9;
      de = (r == 7 || r == 8 || r == 9);
      step($urandom_range(0, 399) == 0, v, AW'($urandom), {$urandom, $urandom}, se, de,
           EW'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
    end

    idle(0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) fail_now("expected states never observed");
    if (beat_q.size() != 0) fail_now("expected beats never forwarded");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
